// File: rtl/mem_stream_pkg.sv
// Shared types for the streaming memory reader.
package mem_stream_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      FLUSH = 2'd2
   } rd_state_e;

endpackage

// File: rtl/mem_stream_reader_fifo2.sv
// Two-entry synchronous FIFO; head word is always presented on o_data.
module fifo2 #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_pop,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [1:0]            o_count,
   output logic                  o_empty,
   output logic                  o_full
);

   logic [DATA_WIDTH-1:0] r_q0;
   logic [DATA_WIDTH-1:0] r_q1;
   logic [1:0]            r_count;
   logic                  w_pop;
   logic                  w_push;

   assign w_pop  = i_pop & (r_count != 2'd0);
   assign w_push = i_push & ((r_count != 2'd2) | w_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q0    <= '0;
         r_q1    <= '0;
         r_count <= 2'd0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) r_q0 <= i_data;
               else                 r_q1 <= i_data;
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_q0    <= r_q1;
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               // Simultaneous push/pop: the incoming word lands behind whatever remains.
               if (r_count == 2'd1) begin
                  r_q0 <= i_data;
               end else begin
                  r_q0 <= r_q1;
                  r_q1 <= i_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_data  = r_q0;
   assign o_count = r_count;
   assign o_empty = (r_count == 2'd0);
   assign o_full  = (r_count == 2'd2);

endmodule

// File: rtl/mem_stream_reader.sv
// Burst read initiator for mem_simple, streaming words out on valid/ready.
// state | meaning
// IDLE  | waiting for i_start
// READ  | issuing sequential reads, throttled by buffer room
// FLUSH | all reads issued, draining buffer before o_done
module mem_stream_reader
   import mem_stream_pkg::*;
#(
   parameter int NUM_ENTRIES = 64,
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = $clog2(NUM_ENTRIES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_base_addr,
   input  logic [ADDR_WIDTH:0]   i_len,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_cenb,
   output logic                  o_wenb,
   output logic [ADDR_WIDTH-1:0] o_addr,
   input  logic [DATA_WIDTH-1:0] i_mem_data,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   input  logic                  i_ready
);

   rd_state_e             r_state;
   rd_state_e             w_next_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH-1:0] w_addr_nxt;
   logic [ADDR_WIDTH:0]   r_remain;
   logic                  r_pending;
   logic                  r_zero_done;
   logic                  w_issue;
   logic                  w_slot;
   logic                  w_pop;
   logic [1:0]            w_count;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_accept;

   fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (r_pending),
      .i_data  (i_mem_data),
      .i_pop   (w_pop),
      .o_data  (o_data),
      .o_count (w_count),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   assign o_valid  = ~w_empty;
   assign w_pop    = o_valid & i_ready;
   assign w_accept = (r_state == IDLE) & i_start;

   // count + pending - pop < 2, with count + pending never exceeding 2
   assign w_slot  = w_pop | (~w_full & ~(r_pending & (w_count == 2'd1)));
   assign w_issue = (r_state == READ) & (r_remain != '0) & w_slot;

   assign w_addr_nxt = (r_addr == ADDR_WIDTH'(NUM_ENTRIES - 1)) ? '0 : r_addr + ADDR_WIDTH'(1);

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (i_start && (i_len != '0)) w_next_state = READ;
         READ:    if (w_issue && (r_remain == (ADDR_WIDTH+1)'(1))) w_next_state = FLUSH;
         FLUSH:   if (w_empty && !r_pending) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      o_busy = (r_state != IDLE);
      o_done = r_zero_done | ((r_state == FLUSH) & w_empty & ~r_pending);
      o_cenb = ~w_issue;
      o_wenb = 1'b1;
      o_addr = r_addr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr      <= '0;
         r_remain    <= '0;
         r_pending   <= 1'b0;
         r_zero_done <= 1'b0;
      end else begin
         r_pending   <= w_issue;
         r_zero_done <= w_accept & (i_len == '0);
         if (w_accept && (i_len != '0)) begin
            r_addr   <= i_base_addr;
            r_remain <= i_len;
         end else if (w_issue) begin
            r_addr   <= w_addr_nxt;
            r_remain <= r_remain - (ADDR_WIDTH+1)'(1);
         end
      end
   end

endmodule
